// File: rtl/pulse_cmd_fifo.sv
// Elastic in-order buffer from core pulse-command strobes to the signal generator; head visible one cycle after its strobe.
// Element backpressure via out_ready; strobes arriving while full (with no same-cycle pop) are dropped, flagged and counted.
module pulse_cmd_fifo #(
  parameter int CMD_WIDTH = 72,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CMD_WIDTH-1:0] cmd_in,
  input  logic                 cstrobe_in,
  input  logic                 out_ready,
  input  logic                 clear_overflow,
  output logic                 out_valid,
  output logic [15:0]          out_amp,
  output logic [15:0]          out_phase,
  output logic [23:0]          out_freq,
  output logic [11:0]          out_env_addr,
  output logic [3:0]           out_cfg,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full,
  output logic                 overflow,
  output logic [7:0]           drop_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [CMD_WIDTH-1:0] mem_q [DEPTH];
  logic [CMD_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  logic                 pop;
  logic                 push;
  logic                 drop;
  logic                 is_full;
  logic [CMD_WIDTH-1:0] head;

  assign is_full = (count_q == CNT_WIDTH'(DEPTH));
  assign pop     = (count_q != '0) & out_ready;
  // A pop in the same cycle frees the slot the push needs, so full does not block it.
  assign push    = cstrobe_in & (~is_full | pop);
  assign drop    = cstrobe_in & is_full & ~pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = cmd_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign out_valid    = (count_q != '0);
  assign out_amp      = head[71:56];
  assign out_phase    = head[55:40];
  assign out_freq     = head[39:16];
  assign out_env_addr = head[15:4];
  assign out_cfg      = head[3:0];
  assign count        = count_q;
  assign full         = is_full;
  assign overflow     = overflow_q;
  assign drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_pulse_cmd_fifo.sv
// Directed self-checking bench for pulse_cmd_fifo (DEPTH=4); inputs driven and outputs sampled on the falling edge.
module tb_pulse_cmd_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [71:0] cmd_in = '0;
  logic        cstrobe_in = 1'b0;
  logic        out_ready = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        out_valid;
  logic [15:0] out_amp;
  logic [15:0] out_phase;
  logic [23:0] out_freq;
  logic [11:0] out_env_addr;
  logic [3:0]  out_cfg;
  logic [2:0]  count;
  logic        full;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [71:0] head;

  int n_checks = 0;
  int n_errors = 0;

  pulse_cmd_fifo #(.CMD_WIDTH(72), .DEPTH(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .cmd_in(cmd_in), .cstrobe_in(cstrobe_in),
    .out_ready(out_ready), .clear_overflow(clear_overflow), .out_valid(out_valid),
    .out_amp(out_amp), .out_phase(out_phase), .out_freq(out_freq),
    .out_env_addr(out_env_addr), .out_cfg(out_cfg), .count(count), .full(full),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  assign head = {out_amp, out_phase, out_freq, out_env_addr, out_cfg};

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [71:0] mk(input int i);
    logic [71:0] v;
    v = {i[7:0], 64'hFEED_FACE_0000_0000} | {40'h0, i};
    return v;
  endfunction

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_head", head, 0);
    reset = 1'b0;
    tick();

    // Single command, field decode, one-cycle latency
    cmd_in = 72'hABCD_1234_56789A_FED_7;
    cstrobe_in = 1'b1;
    tick();
    cstrobe_in = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_amp", out_amp, 16'hABCD);
    chk("single_phase", out_phase, 16'h1234);
    chk("single_freq", out_freq, 24'h56789A);
    chk("single_env", out_env_addr, 12'hFED);
    chk("single_cfg", out_cfg, 4'h7);
    chk("single_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_pop_valid", out_valid, 0);
    chk("single_pop_count", count, 0);

    // Out_ready while empty has no effect
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("empty_ready_count", count, 0);

    // Fill and overflow
    for (int i = 0; i < 6; i++) begin
      cmd_in = mk(i);
      cstrobe_in = 1'b1;
      tick();
    end
    cstrobe_in = 1'b0;
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    chk("fill_ovf", overflow, 1);
    chk("fill_drop", drop_count, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_head", head, mk(i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", out_valid, 0);
    chk("drain_full", full, 0);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_drop", drop_count, 0);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) begin
      cmd_in = mk(100 + i);
      cstrobe_in = 1'b1;
      tick();
    end
    cmd_in = mk(104);
    out_ready = 1'b1;
    tick();
    cstrobe_in = 1'b0;
    chk("pp_count", count, 4);
    chk("pp_ovf", overflow, 0);
    chk("pp_drop", drop_count, 0);
    for (int i = 1; i < 5; i++) begin
      chk("pp_head", head, mk(100 + i));
      tick();
    end
    out_ready = 1'b0;
    chk("pp_empty", out_valid, 0);

    // Pointer wrap with continuous streaming
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cmd_in = mk(200 + i);
      cstrobe_in = 1'b1;
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_head", head, mk(200 + i));
      chk("stream_count_le1", (count <= 3'd1), 1);
    end
    cstrobe_in = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("stream_end_valid", out_valid, 0);

    // Saturation and clear
    for (int i = 0; i < 4; i++) begin
      cmd_in = mk(50 + i);
      cstrobe_in = 1'b1;
      tick();
    end
    cmd_in = mk(99);
    for (int i = 0; i < 254; i++) tick();
    chk("sat_254", drop_count, 254);
    for (int i = 0; i < 46; i++) tick();
    chk("sat_255", drop_count, 255);
    chk("sat_ovf", overflow, 1);
    chk("sat_head", head, mk(50));
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    cstrobe_in = 1'b0;
    chk("clr_drop_prio_ovf", overflow, 0);
    chk("clr_drop_prio_cnt", drop_count, 0);
    chk("clr_count", count, 4);

    // Asynchronous reset mid-stream
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pre_rst_count", count, 3);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_full", full, 0);
    @(negedge clk);
    reset = 1'b0;
    cmd_in = mk(77);
    cstrobe_in = 1'b1;
    tick();
    cstrobe_in = 1'b0;
    chk("post_rst_count", count, 1);
    chk("post_rst_head", head, mk(77));
    chk("post_rst_valid", out_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulse_cmd_fifo.md
# pulse_cmd_fifo

Elastic buffer between the processor core's pulse-command output and the signal-generator element. Captures the 72-bit pulse command on every command strobe, holds up to DEPTH commands in order, and presents them field-decoded to the element over a valid/ready handshake. Commands strobed while the buffer is full are dropped. Drops are flagged sticky and counted so that software can detect timing violations.

## Interface
Parameters:
- CMD_WIDTH, 72, pulse command width; fixed field layout below requires 72.
- DEPTH, 4, buffer entries; power of two, 2..16.
- CNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- cmd_in  in  72  pulse command from the core; sampled only when cstrobe_in=1.
- cstrobe_in  in  1  command strobe; one cycle per command, may assert on consecutive cycles.
- out_ready  in  1  element accepts the head command this cycle.
- clear_overflow  in  1  clears overflow and drop_count.
- out_valid  out  1  head entry is valid.
- out_amp  out  16  cmd[71:56] of head.
- out_phase  out  16  cmd[55:40] of head.
- out_freq  out  24  cmd[39:16] of head.
- out_env_addr  out  12  cmd[15:4] of head.
- out_cfg  out  4  cmd[3:0] of head.
- count  out  CNT_WIDTH  entries currently held, 0..DEPTH.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: at least one command was dropped.
- drop_count  out  8  dropped commands, saturating at 255.

## Operation
- Storage: DEPTH x 72 register array, write pointer wr_ptr and read pointer rd_ptr, each log2(DEPTH) bits and wrapping modulo DEPTH. Occupancy is held in the count register.
- pop = out_valid & out_ready.
- push = cstrobe_in & (!full | pop). When full, a push is accepted if a pop happens in the same cycle.
- On push: mem[wr_ptr] <= cmd_in; wr_ptr++.
- On pop: rd_ptr++.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Drop = cstrobe_in & full & !pop. On a drop: overflow <= 1 and drop_count <= min(drop_count+1, 255). The buffer contents and pointers are unchanged.
- clear_overflow takes priority over a drop in the same cycle: both overflow and drop_count go to 0.
- out_valid = (count != 0). Output fields are a combinational slice of mem[rd_ptr]. Fields are don't-care when out_valid=0 but must not be X after reset; the array resets to 0.
- out_ready while out_valid=0 is ignored and has no side effects.
- cmd_in is ignored while cstrobe_in=0.

## Timing
- Reset values:
  - out_valid=0, count=0, full=0, overflow=0, drop_count=0.
  - All field outputs 0; pointers 0.
- Reset is asynchronous. Asserting it mid-operation discards all entries immediately, with no partial pop.
- Latency: a strobe at edge N into an empty buffer gives out_valid=1 with that command's fields after edge N. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle, sustained.
- out_valid and the head fields stay stable until popped. Once out_valid=1, it does not deassert without a pop or a reset.
- full, count, and overflow are registered-derived and update on the clock edge after the causing event.

## Test plan
- Single command: reset, then strobe cmd_in=72'hABCD_1234_56789A_FED_7 -> next cycle out_valid=1, out_amp=16'hABCD, out_phase=16'h1234, out_freq=24'h56789A, out_env_addr=12'hFED, out_cfg=4'h7, count=1. Then out_ready for 1 cycle -> out_valid=0, count=0.
- Fill and overflow: out_ready=0, strobe 6 distinct commands back-to-back with DEPTH=4 -> full=1, count=4, overflow=1, drop_count=2. Then drain with out_ready=1 -> the first 4 commands come out in order, and out_valid drops after the 4th pop.
- Push+pop at full: fill 4 entries, then strobe with out_ready=1 in the same cycle -> no drop, count stays 4, the new command becomes the last entry, and overflow stays 0.
- Pointer wrap: stream 20 commands with out_ready=1 continuously and strobes every cycle -> all 20 are received in order, each 1 cycle after its strobe, with count ≤ 1 throughout.
- Saturation and clear: 300 strobes with the buffer held full -> drop_count=255, overflow=1. Then clear_overflow together with a drop in the same cycle -> both 0 next cycle.
- Reset mid-stream: 3 entries held, assert reset between clock edges -> out_valid, count, and full go to 0 immediately. After release, one strobe gives count=1 with the new command at the head.
